pblaze_port_responder: RTL

- Port-mapped peripheral on the KCPSM6 I/O bus. It answers INPUT/OUTPUT/OUTPUTK cycles issued by the processor wrapper.
- Decodes port_id, holds two control output registers, and buffers an external byte stream in an RX FIFO that the processor drains.
- Drives the processor interrupt line and completes the interrupt/interrupt_ack handshake.

---
 rtl/pblaze_port_responder_if.sv | 41 ++++
 rtl/pblaze_port_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pblaze_port_responder_if.sv
// -----------------------------------------------------------------------------
// pblaze_port_responder_if
// Bundles the KCPSM6 I/O bus, interrupt handshake, RX byte stream, status
// inputs and control outputs of the port responder into one interface.
//   slave  : the peripheral side (pblaze_port_responder)
//   master : the processor/environment side (wrapper or testbench)
// Signals:
//   port_id[7:0], out_port[7:0], write_strobe, k_write_strobe, read_strobe
//   in_port[7:0]   registered read data back to the processor
//   interrupt, interrupt_ack
//   rx_data[7:0], rx_valid, rx_ready
//   gpio_in[7:0], ctrl0[7:0], ctrl1[7:0]
// -----------------------------------------------------------------------------
interface pblaze_port_responder_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] gpio_in;
  logic [7:0] ctrl0;
  logic [7:0] ctrl1;

  modport slave (
    input  port_id, out_port, write_strobe, k_write_strobe, read_strobe,
    input  interrupt_ack, rx_data, rx_valid, gpio_in,
    output in_port, interrupt, rx_ready, ctrl0, ctrl1
  );

  modport master (
    output port_id, out_port, write_strobe, k_write_strobe, read_strobe,
    output interrupt_ack, rx_data, rx_valid, gpio_in,
    input  in_port, interrupt, rx_ready, ctrl0, ctrl1
  );
endinterface

// File: rtl/pblaze_port_responder.sv
// -----------------------------------------------------------------------------
// pblaze_port_responder
// Port-mapped peripheral on the KCPSM6 I/O bus. Decodes port_id, holds two
// control registers and an interrupt-enable register, buffers an external byte
// stream in an RX FIFO drained by the processor, and drives the interrupt line
// with a request/acknowledge handshake.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    pblaze_port_responder_if.slave (I/O bus, irq, RX stream, gpio, ctrl)
// Address map (port_id[7:3] == PORT_BASE[7:3], offset = port_id[2:0]):
//   0 R  {5'b0, ovf, full, empty}   1 R  FIFO head (pops)
//   2 RW ctrl0                      3 RW ctrl1
//   4 R  gpio_in                    5 RW {6'b0, ie[1:0]}
//   6 W  bit0=1 clears ovf          7    reserved (reads 0x00)
// OUTPUTK decodes port_id[3:0] only: 4'h2 -> ctrl0, 4'h3 -> ctrl1.
// Build option:
//   PBLAZE_GPIO_SYNC_EN  when defined, gpio_in passes through a 2-flop
//                        synchronizer before the read mux (3-cycle latency
//                        to in_port instead of 1).
// -----------------------------------------------------------------------------
module pblaze_port_responder #(
  parameter logic [7:0] PORT_BASE  = 8'h00,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] CTRL0_RST  = 8'h00,
  parameter logic [7:0] CTRL1_RST  = 8'h00
) (
  input logic                    clk,
  input logic                    reset,
  pblaze_port_responder_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_ASSERT     = 2'b01;
  localparam logic [1:0] ST_WAIT_CLEAR = 2'b10;

  // State registers
  logic [7:0]    ctrl0_q, ctrl0_d;
  logic [7:0]    ctrl1_q, ctrl1_d;
  logic [1:0]    ie_q, ie_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [1:0]    irq_state_q, irq_state_d;
  logic          irq_q;
  logic [7:0]    in_port_q;
  logic          rx_ready_q;

  // Decode and datapath signals
  logic          base_hit_s;
  logic [2:0]    offset_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          ovf_set_s;
  logic          ovf_clr_s;
  logic          out_wr_s;
  logic          cause_s;
  logic [7:0]    gpio_view_s;
  logic [7:0]    rd_data_s;

  // Address decode, FIFO flags and the transfer qualifiers derived from them
  always_comb begin
    base_hit_s = (bus.port_id[7:3] == PORT_BASE[7:3]);
    offset_s   = bus.port_id[2:0];
    full_s     = (count_q == DEPTH_C);
    empty_s    = (count_q == {CW{1'b0}});
    push_s     = bus.rx_valid & ~full_s;
    pop_s      = bus.read_strobe & base_hit_s & (offset_s == 3'd1) & ~empty_s;
    ovf_set_s  = bus.rx_valid & full_s;
    out_wr_s   = bus.write_strobe & base_hit_s;
    ovf_clr_s  = out_wr_s & (offset_s == 3'd6) & bus.out_port[0];
    cause_s    = (ie_q[0] & ~empty_s) | (ie_q[1] & ovf_q);
  end

  // Register-file next state from OUTPUT / OUTPUTK writes and overflow events
  always_comb begin
    ctrl0_d = ctrl0_q;
    ctrl1_d = ctrl1_q;
    ie_d    = ie_q;
    ovf_d   = ovf_q;
    if (out_wr_s && (offset_s == 3'd2)) begin
      ctrl0_d = bus.out_port;
    end else if (bus.k_write_strobe && (bus.port_id[3:0] == 4'h2)) begin
      ctrl0_d = bus.out_port;
    end else begin
      ctrl0_d = ctrl0_q;
    end
    if (out_wr_s && (offset_s == 3'd3)) begin
      ctrl1_d = bus.out_port;
    end else if (bus.k_write_strobe && (bus.port_id[3:0] == 4'h3)) begin
      ctrl1_d = bus.out_port;
    end else begin
      ctrl1_d = ctrl1_q;
    end
    if (out_wr_s && (offset_s == 3'd5)) begin
      ie_d = bus.out_port[1:0];
    end else begin
      ie_d = ie_q;
    end
    // A fresh overflow outranks a clear arriving in the same cycle.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO pointer and occupancy next state; pointers wrap at the power-of-two depth
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef PBLAZE_GPIO_SYNC_EN
  logic [7:0] gpio_meta_q;
  logic [7:0] gpio_sync_q;

  // Two-flop synchronizer for asynchronous status inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_meta_q <= 8'h00;
      gpio_sync_q <= 8'h00;
    end else begin
      gpio_meta_q <= bus.gpio_in;
      gpio_sync_q <= gpio_meta_q;
    end
  end

  assign gpio_view_s = gpio_sync_q;
`else
  assign gpio_view_s = bus.gpio_in;
`endif

  // Read mux; the head of an empty FIFO reads as zero
  always_comb begin
    rd_data_s = 8'h00;
    if (base_hit_s) begin
      case (offset_s)
        3'd0:    rd_data_s = {5'b00000, ovf_q, full_s, empty_s};
        3'd1:    rd_data_s = empty_s ? 8'h00 : mem_q[rd_ptr_q];
        3'd2:    rd_data_s = ctrl0_q;
        3'd3:    rd_data_s = ctrl1_q;
        3'd4:    rd_data_s = gpio_view_s;
        3'd5:    rd_data_s = {6'b000000, ie_q};
        default: rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Interrupt FSM: one request per cause episode, re-armed only once cause drops
  always_comb begin
    irq_state_d = irq_state_q;
    case (irq_state_q)
      ST_IDLE: begin
        if (cause_s) irq_state_d = ST_ASSERT;
        else         irq_state_d = ST_IDLE;
      end
      ST_ASSERT: begin
        if (bus.interrupt_ack) irq_state_d = ST_WAIT_CLEAR;
        else                   irq_state_d = ST_ASSERT;
      end
      ST_WAIT_CLEAR: begin
        if (!cause_s) irq_state_d = ST_IDLE;
        else          irq_state_d = ST_WAIT_CLEAR;
      end
      default: irq_state_d = ST_IDLE;
    endcase
  end

  // Control/status registers, FIFO bookkeeping, FSM and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl0_q     <= CTRL0_RST;
      ctrl1_q     <= CTRL1_RST;
      ie_q        <= 2'b00;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      irq_state_q <= ST_IDLE;
      irq_q       <= 1'b0;
      in_port_q   <= 8'h00;
      rx_ready_q  <= 1'b1;
    end else begin
      ctrl0_q     <= ctrl0_d;
      ctrl1_q     <= ctrl1_d;
      ie_q        <= ie_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      irq_state_q <= irq_state_d;
      irq_q       <= (irq_state_d == ST_ASSERT);
      in_port_q   <= rd_data_s;
      rx_ready_q  <= (count_d != DEPTH_C);
    end
  end

  // FIFO storage; contents are abandoned on reset by clearing the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.rx_data;
    end
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_q;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.ctrl0     = ctrl0_q;
  assign bus.ctrl1     = ctrl1_q;

endmodule
